// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types for the token/timer processor bank.
//   instr_e : programming instruction codes (unlisted codes act as NOP)
//   event_e : output event codes driven on token_startstop
//   state_e : bank controller FSM states
package ttt_pkg;

    typedef enum logic [2:0] {
        INSTR_NOP          = 3'b000,
        INSTR_SET_START    = 3'b001,
        INSTR_SET_STOP     = 3'b010,
        INSTR_SET_DURATION = 3'b011,
        INSTR_CLEAR        = 3'b100
    } instr_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_START = 2'b01,
        EV_STOP  = 2'b10
    } event_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_SWEEP
    } state_e;

endpackage

// File: rtl/ttt_token_alu.sv
// ttt_token_alu: saturating token update plus start/stop threshold compare.
//   i_tokens     current token count
//   i_good/i_bad increment / decrement applied this update
//   i_active     processor currently active
//   i_start_thr  start threshold (inactive -> active when new count >= it)
//   i_stop_thr   stop threshold (active -> inactive when new count < it)
//   o_tokens     new count, clamped to [0, 2^TOKENS_BITS-1]
//   o_start      start event condition
//   o_stop       stop event condition
module ttt_token_alu
    import ttt_pkg::*;
#(
    parameter int NEW_TOKENS_BITS = 8,
    parameter int TOKENS_BITS     = 8
) (
    input  logic [TOKENS_BITS-1:0]     i_tokens,
    input  logic [NEW_TOKENS_BITS-1:0] i_good,
    input  logic [NEW_TOKENS_BITS-1:0] i_bad,
    input  logic                       i_active,
    input  logic [TOKENS_BITS-1:0]     i_start_thr,
    input  logic [TOKENS_BITS-1:0]     i_stop_thr,
    output logic [TOKENS_BITS-1:0]     o_tokens,
    output logic                       o_start,
    output logic                       o_stop
);

    // Two guard bits: one for the carry of the addition, one for the sign.
    localparam int SUM_W = ((TOKENS_BITS > NEW_TOKENS_BITS) ? TOKENS_BITS : NEW_TOKENS_BITS) + 2;

    logic signed [SUM_W-1:0] w_sum;

    assign w_sum = $signed(SUM_W'(i_tokens)) + $signed(SUM_W'(i_good)) - $signed(SUM_W'(i_bad));

    // Negative -> 0; any bit above the counter width -> all ones.
    always_comb begin
        if (w_sum[SUM_W-1]) begin
            o_tokens = '0;
        end else if (|w_sum[SUM_W-2:TOKENS_BITS]) begin
            o_tokens = '1;
        end else begin
            o_tokens = w_sum[TOKENS_BITS-1:0];
        end
    end

    assign o_start = !i_active && (o_tokens >= i_start_thr);
    assign o_stop  = i_active && (o_tokens < i_stop_thr);

endmodule

// File: rtl/tt_um_jleugeri_ttt_processor_bank.sv
// tt_um_jleugeri_ttt_processor_bank: bank of NUM_PROCESSORS token/timer
// processors sharing one update ALU and one output event register.
//   clock_fast, reset           sole clock, async active-high reset
//   tick                        timebase strobe; requests one sweep of all timers
//   hold                        freezes token updates and sweeps
//   in_valid/in_ready, in_id, new_good_tokens, new_bad_tokens
//                               token transfer into one processor
//   prog_valid/prog_ready, prog_id, instruction, prog_data
//                               parameter programming
//   out_valid/out_ready, out_id, token_startstop
//                               start/stop event output (00 when not valid)
module tt_um_jleugeri_ttt_processor_bank
    import ttt_pkg::*;
#(
    parameter int NEW_TOKENS_BITS = 8,
    parameter int TOKENS_BITS     = 8,
    parameter int DURATION_BITS   = 8,
    parameter int NUM_PROCESSORS  = 10,
    parameter int PROG_WIDTH      = 8,
    localparam int PID_W          = $clog2(NUM_PROCESSORS)
) (
    input  logic                       clock_fast,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       hold,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PID_W-1:0]           in_id,
    input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
    input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    input  logic                       prog_valid,
    output logic                       prog_ready,
    input  logic [PID_W-1:0]           prog_id,
    input  logic [2:0]                 instruction,
    input  logic [PROG_WIDTH-1:0]      prog_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PID_W-1:0]           out_id,
    output logic [1:0]                 token_startstop
);

    localparam logic [PID_W:0]   NUM_P  = (PID_W+1)'(NUM_PROCESSORS);
    localparam logic [PID_W-1:0] LAST_P = PID_W'(NUM_PROCESSORS - 1);

    // Per-processor state and parameters
    logic [TOKENS_BITS-1:0]     r_tokens    [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0]   r_remaining [NUM_PROCESSORS];
    logic                       r_active    [NUM_PROCESSORS];
    logic [TOKENS_BITS-1:0]     r_start_thr [NUM_PROCESSORS];
    logic [TOKENS_BITS-1:0]     r_stop_thr  [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0]   r_duration  [NUM_PROCESSORS];

    // Controller state
    state_e                     r_state;
    logic                       r_pending;
    logic [PID_W-1:0]           r_upd_id;
    logic [NEW_TOKENS_BITS-1:0] r_upd_good;
    logic [NEW_TOKENS_BITS-1:0] r_upd_bad;
    logic [PID_W-1:0]           r_sweep_idx;
    logic                       r_out_valid;
    logic [PID_W-1:0]           r_out_id;
    event_e                     r_out_code;

    logic                       w_out_free;
    logic                       w_in_fire;
    logic                       w_prog_fire;
    logic                       w_prog_id_ok;
    logic                       w_upd_id_ok;
    logic                       w_start_sweep;
    logic                       w_sweep_step;
    logic [TOKENS_BITS-1:0]     w_new_tokens;
    logic                       w_do_start;
    logic                       w_do_stop;

    assign w_out_free   = !r_out_valid || out_ready;
    assign in_ready     = !reset && (r_state == ST_IDLE) && !hold && !r_pending && w_out_free;
    assign prog_ready   = !reset && (r_state == ST_IDLE);
    assign w_in_fire    = in_valid && in_ready;
    assign w_prog_fire  = prog_valid && prog_ready;
    assign w_prog_id_ok = {1'b0, prog_id} < NUM_P;
    assign w_upd_id_ok  = {1'b0, r_upd_id} < NUM_P;

    // in_ready already excludes a set pending flag, so a transfer can only
    // win against a tick in the very cycle that tick arrives.
    assign w_start_sweep = (r_state == ST_IDLE) && r_pending && !hold && !w_in_fire && w_out_free;
    assign w_sweep_step  = (r_state == ST_SWEEP) && !hold && w_out_free;

    assign out_valid       = r_out_valid;
    assign out_id          = r_out_id;
    assign token_startstop = r_out_valid ? r_out_code : EV_NONE;

    ttt_token_alu #(
        .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
        .TOKENS_BITS    (TOKENS_BITS)
    ) u_alu (
        .i_tokens   (r_tokens[r_upd_id]),
        .i_good     (r_upd_good),
        .i_bad      (r_upd_bad),
        .i_active   (r_active[r_upd_id]),
        .i_start_thr(r_start_thr[r_upd_id]),
        .i_stop_thr (r_stop_thr[r_upd_id]),
        .o_tokens   (w_new_tokens),
        .o_start    (w_do_start),
        .o_stop     (w_do_stop)
    );

    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            r_tokens    <= '{default: '0};
            r_remaining <= '{default: '0};
            r_active    <= '{default: 1'b0};
            r_start_thr <= '{default: '0};
            r_stop_thr  <= '{default: '0};
            r_duration  <= '{default: '0};
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_upd_id    <= '0;
            r_upd_good  <= '0;
            r_upd_bad   <= '0;
            r_sweep_idx <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_code  <= EV_NONE;
        end else begin
            // Drain the output register; a new event below overrides this.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_code  <= EV_NONE;
            end

            // The flag is consumed when its sweep starts, so a tick arriving
            // during that sweep queues exactly one follow-up sweep.
            if (tick) begin
                r_pending <= 1'b1;
            end else if (w_start_sweep) begin
                r_pending <= 1'b0;
            end

            if (w_prog_fire && w_prog_id_ok) begin
                case (instruction)
                    INSTR_SET_START:    r_start_thr[prog_id] <= TOKENS_BITS'(prog_data);
                    INSTR_SET_STOP:     r_stop_thr[prog_id]  <= TOKENS_BITS'(prog_data);
                    INSTR_SET_DURATION: r_duration[prog_id]  <= DURATION_BITS'(prog_data);
                    INSTR_CLEAR: begin
                        r_tokens[prog_id]    <= '0;
                        r_remaining[prog_id] <= '0;
                        r_active[prog_id]    <= 1'b0;
                    end
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_upd_id   <= in_id;
                        r_upd_good <= new_good_tokens;
                        r_upd_bad  <= new_bad_tokens;
                        r_state    <= ST_UPDATE;
                    end else if (w_start_sweep) begin
                        r_sweep_idx <= '0;
                        r_state     <= ST_SWEEP;
                    end
                end

                ST_UPDATE: begin
                    if (!hold) begin
                        if (w_upd_id_ok) begin
                            r_tokens[r_upd_id] <= w_new_tokens;
                            if (w_do_start) begin
                                r_active[r_upd_id]    <= 1'b1;
                                r_remaining[r_upd_id] <= r_duration[r_upd_id];
                                r_out_valid           <= 1'b1;
                                r_out_id              <= r_upd_id;
                                r_out_code            <= EV_START;
                            end else if (w_do_stop) begin
                                r_active[r_upd_id] <= 1'b0;
                                r_out_valid        <= 1'b1;
                                r_out_id           <= r_upd_id;
                                r_out_code         <= EV_STOP;
                            end
                        end
                        r_state <= ST_IDLE;
                    end
                end

                ST_SWEEP: begin
                    if (w_sweep_step) begin
                        if (r_active[r_sweep_idx]) begin
                            if (r_remaining[r_sweep_idx] > DURATION_BITS'(1)) begin
                                r_remaining[r_sweep_idx] <= r_remaining[r_sweep_idx] - DURATION_BITS'(1);
                            end else begin
                                r_active[r_sweep_idx]    <= 1'b0;
                                r_remaining[r_sweep_idx] <= '0;
                                r_out_valid              <= 1'b1;
                                r_out_id                 <= r_sweep_idx;
                                r_out_code               <= EV_STOP;
                            end
                        end
                        if (r_sweep_idx == LAST_P) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_sweep_idx <= r_sweep_idx + PID_W'(1);
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_processor_bank.sv
module tb_tt_um_jleugeri_ttt_processor_bank;

    localparam int NP = 10;

    logic       clock_fast = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       hold = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_id = '0;
    logic [7:0] new_good_tokens = '0;
    logic [7:0] new_bad_tokens = '0;
    logic       prog_valid = 1'b0;
    logic       prog_ready;
    logic [3:0] prog_id = '0;
    logic [2:0] instruction = '0;
    logic [7:0] prog_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_id;
    logic [1:0] token_startstop;

    int n_tests = 0;
    int n_fail  = 0;

    // events encoded as id*4 + code
    int got_q[$];
    int exp_q[$];

    // reference model state
    int m_tok[NP];
    int m_rem[NP];
    int m_act[NP];
    int m_sth[NP];
    int m_pth[NP];
    int m_dur[NP];

    typedef struct {
        int id;
        int good;
        int bad;
        int code;
        int tok;
    } vec_t;
    vec_t vecs[11];

    tt_um_jleugeri_ttt_processor_bank #(
        .NEW_TOKENS_BITS(8),
        .TOKENS_BITS    (8),
        .DURATION_BITS  (8),
        .NUM_PROCESSORS (NP),
        .PROG_WIDTH     (8)
    ) dut (
        .clock_fast     (clock_fast),
        .reset          (reset),
        .tick           (tick),
        .hold           (hold),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_id          (in_id),
        .new_good_tokens(new_good_tokens),
        .new_bad_tokens (new_bad_tokens),
        .prog_valid     (prog_valid),
        .prog_ready     (prog_ready),
        .prog_id        (prog_id),
        .instruction    (instruction),
        .prog_data      (prog_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_id         (out_id),
        .token_startstop(token_startstop)
    );

    always #5 clock_fast = ~clock_fast;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Event monitor: sampled on the falling edge, handshake completes on the next rising edge.
    always @(negedge clock_fast) begin
        if (!reset) begin
            if (out_valid && out_ready) got_q.push_back(int'(out_id) * 4 + int'(token_startstop));
            if (!out_valid) check("idle_code_zero", int'(token_startstop), 0);
        end
    end

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int i = 0; i < NP; i++) begin
            m_tok[i] = 0; m_rem[i] = 0; m_act[i] = 0;
            m_sth[i] = 0; m_pth[i] = 0; m_dur[i] = 0;
        end
    endfunction

    function automatic void m_prog(input int id, input int ins, input int data);
        if (id >= NP) return;
        case (ins)
            1: m_sth[id] = data;
            2: m_pth[id] = data;
            3: m_dur[id] = data;
            4: begin m_tok[id] = 0; m_rem[id] = 0; m_act[id] = 0; end
            default: ;
        endcase
    endfunction

    function automatic void m_transfer(input int id, input int g, input int b);
        int t;
        if (id >= NP) return;
        t = m_tok[id] + g - b;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        m_tok[id] = t;
        if (m_act[id] == 0 && t >= m_sth[id]) begin
            m_act[id] = 1;
            m_rem[id] = m_dur[id];
            exp_q.push_back(id * 4 + 1);
        end else if (m_act[id] != 0 && t < m_pth[id]) begin
            m_act[id] = 0;
            exp_q.push_back(id * 4 + 2);
        end
    endfunction

    function automatic void m_sweep();
        for (int id = 0; id < NP; id++) begin
            if (m_act[id] != 0) begin
                if (m_rem[id] > 1) m_rem[id]--;
                else begin
                    m_act[id] = 0;
                    m_rem[id] = 0;
                    exp_q.push_back(id * 4 + 2);
                end
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock_fast);
            #1;
        end
    endtask

    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        @(negedge clock_fast);
        while (!in_ready && n < 400) begin
            @(negedge clock_fast);
            n++;
        end
        check({name, ".in_ready_reached"}, int'(in_ready), 1);
    endtask

    task automatic wait_prog_ready(input string name);
        int n;
        n = 0;
        @(negedge clock_fast);
        while (!prog_ready && n < 400) begin
            @(negedge clock_fast);
            n++;
        end
        check({name, ".prog_ready_reached"}, int'(prog_ready), 1);
    endtask

    task automatic send(input int id, input int g, input int b);
        in_id = 4'(id);
        new_good_tokens = 8'(g);
        new_bad_tokens = 8'(b);
        in_valid = 1'b1;
        wait_in_ready("send");
        @(posedge clock_fast);
        #1;
        in_valid = 1'b0;
        cyc(4);
    endtask

    task automatic prog(input int id, input int ins, input int data);
        prog_id = 4'(id);
        instruction = 3'(ins);
        prog_data = 8'(data);
        prog_valid = 1'b1;
        wait_prog_ready("prog");
        @(posedge clock_fast);
        #1;
        prog_valid = 1'b0;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        @(posedge clock_fast);
        #1;
        tick = 1'b0;
    endtask

    task automatic sweep();
        tick_pulse();
        wait_in_ready("sweep");
        cyc(2);
    endtask

    task automatic check_events(input string name);
        check({name, ".event_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, ".event"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = '{5, 250, 0,   1, 250};
        vecs[1]  = '{5, 20,  0,   0, 255};
        vecs[2]  = '{5, 0,   255, 2, 0};
        vecs[3]  = '{5, 10,  50,  0, 0};
        vecs[4]  = '{5, 199, 0,   0, 199};
        vecs[5]  = '{5, 1,   0,   1, 200};
        vecs[6]  = '{5, 0,   101, 2, 99};
        vecs[7]  = '{12, 255, 0,  0, -1};
        vecs[8]  = '{0, 3,   0,   1, 3};
        vecs[9]  = '{0, 0,   3,   0, 0};
        vecs[10] = '{15, 0,  0,   0, -1};

        // ---- reset state ----
        @(negedge clock_fast);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.code", int'(token_startstop), 0);
        check("rst.in_ready", int'(in_ready), 0);
        check("rst.prog_ready", int'(prog_ready), 0);
        @(posedge clock_fast);
        #1;
        reset = 1'b0;
        @(negedge clock_fast);
        check("rst.in_ready_after", int'(in_ready), 1);
        check("rst.prog_ready_after", int'(prog_ready), 1);
        for (int i = 0; i < NP; i++) check("rst.tokens", int'(dut.r_tokens[i]), 0);

        // ---- start event then timeout after three sweeps ----
        cyc(1);
        prog(3, 1, 5);
        prog(3, 2, 2);
        prog(3, 3, 3);
        send(3, 5, 0);
        exp_q.push_back(3 * 4 + 1);
        check_events("seqA.start");
        check("seqA.tokens", int'(dut.r_tokens[3]), 5);
        sweep();
        check_events("seqA.sweep1");
        sweep();
        check_events("seqA.sweep2");
        sweep();
        exp_q.push_back(3 * 4 + 2);
        check_events("seqA.sweep3");

        // ---- restart, then stop held under backpressure ----
        send(3, 0, 0);
        exp_q.push_back(3 * 4 + 1);
        check_events("seqB.restart");
        out_ready = 1'b0;
        send(3, 0, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_fast);
            check("seqB.stall_valid", int'(out_valid), 1);
            check("seqB.stall_code", int'(token_startstop), 2);
            check("seqB.stall_id", int'(out_id), 3);
            check("seqB.stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clock_fast);
        #1;
        out_ready = 1'b1;
        cyc(3);
        exp_q.push_back(3 * 4 + 2);
        check_events("seqB.stop");
        check("seqB.tokens", int'(dut.r_tokens[3]), 1);

        // ---- table-driven saturation / threshold vectors ----
        do_reset();
        prog(5, 1, 200);
        prog(5, 2, 100);
        prog(5, 3, 4);
        for (int v = 0; v < 11; v++) begin
            send(vecs[v].id, vecs[v].good, vecs[v].bad);
            if (vecs[v].code != 0) exp_q.push_back(vecs[v].id * 4 + vecs[v].code);
            check_events($sformatf("vec%0d", v));
            if (vecs[v].tok >= 0)
                check($sformatf("vec%0d.tokens", v), int'(dut.r_tokens[vecs[v].id]), vecs[v].tok);
        end

        // ---- tick coalescing and hold ----
        do_reset();
        prog(1, 1, 1);
        prog(1, 3, 50);
        send(1, 1, 0);
        exp_q.push_back(1 * 4 + 1);
        check_events("seqD.start");
        tick_pulse();
        cyc(3);
        tick_pulse();
        cyc(2);
        tick_pulse();
        wait_in_ready("seqD.sweeps");
        cyc(15);
        check("seqD.two_sweeps", int'(dut.r_remaining[1]), 48);
        hold = 1'b1;
        tick_pulse();
        cyc(20);
        @(negedge clock_fast);
        check("seqD.hold_frozen", int'(dut.r_remaining[1]), 48);
        check("seqD.hold_in_ready", int'(in_ready), 0);
        check("seqD.hold_prog_ready", int'(prog_ready), 1);
        @(posedge clock_fast);
        #1;
        hold = 1'b0;
        wait_in_ready("seqD.release");
        cyc(2);
        check("seqD.after_hold", int'(dut.r_remaining[1]), 47);
        check_events("seqD.no_events");

        // ---- reset mid-sweep with a stop waiting ----
        do_reset();
        prog(0, 1, 1);
        prog(0, 3, 1);
        prog(2, 1, 1);
        prog(2, 3, 1);
        send(0, 1, 0);
        send(2, 1, 0);
        exp_q.push_back(0 * 4 + 1);
        exp_q.push_back(2 * 4 + 1);
        check_events("seqE.starts");
        out_ready = 1'b0;
        tick_pulse();
        cyc(4);
        @(negedge clock_fast);
        check("seqE.pending_valid", int'(out_valid), 1);
        check("seqE.pending_code", int'(token_startstop), 2);
        @(posedge clock_fast);
        #1;
        reset = 1'b1;
        @(negedge clock_fast);
        check("seqE.abort_valid", int'(out_valid), 0);
        check("seqE.abort_code", int'(token_startstop), 0);
        check("seqE.abort_in_ready", int'(in_ready), 0);
        @(posedge clock_fast);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NP; i++) check("seqE.tokens", int'(dut.r_tokens[i]), 0);
        cyc(15);
        check_events("seqE.lost");
        send(12, 50, 0);
        check_events("seqE.bad_id");

        // ---- randomized operations against the model ----
        do_reset();
        m_reset();
        for (int k = 0; k < 200; k++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 2) begin
                int id;
                int ins;
                int data;
                id = int'($urandom_range(0, 11));
                ins = int'($urandom_range(0, 7));
                data = (ins == 3) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 60));
                m_prog(id, ins, data);
                prog(id, ins, data);
                cyc(1);
            end else if (op < 8) begin
                int id;
                int g;
                int b;
                id = int'($urandom_range(0, 11));
                g = int'($urandom_range(0, 40));
                b = int'($urandom_range(0, 40));
                m_transfer(id, g, b);
                send(id, g, b);
                check_events("rand.transfer");
            end else begin
                m_sweep();
                sweep();
                check_events("rand.sweep");
            end
        end
        for (int i = 0; i < NP; i++) check("rand.final_tokens", int'(dut.r_tokens[i]), m_tok[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
